// File: rtl/usb_nrzi_tx.sv
`default_nettype none
// usb_nrzi_tx -- USB transmit line encoder: NRZI, bit stuffing and EOP generation (rev 1.0).
// The FSM state names the current cycle's role; its encoding decision lands on dp/dm at the edge that ends it.
module usb_nrzi_tx #(
  parameter int STUFF_LEN      = 6,
  parameter int EOP_SE0_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_L,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_last,
  output logic in_ready,
  output logic dp,
  output logic dm,
  output logic tx_en,
  output logic err
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam int SW = (EOP_SE0_CYCLES > 1) ? $clog2(EOP_SE0_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA    = 3'd1,
    STUFF   = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } state_t;

  state_t        state;
  logic          level;      // 1 = J, 0 = K
  logic [CW-1:0] ones;
  logic          last_pend;
  logic [SW-1:0] se0_cnt;

  logic enc_level;
  logic stuff_hit;

  always_comb begin
    enc_level = in_bit ? level : ~level;
    stuff_hit = in_bit && (ones == CW'(STUFF_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state     <= IDLE;
      level     <= 1'b1;
      ones      <= '0;
      last_pend <= 1'b0;
      se0_cnt   <= '0;
      dp        <= 1'b1;
      dm        <= 1'b0;
      tx_en     <= 1'b0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE, DATA: begin
          if (in_valid) begin
            level     <= enc_level;
            dp        <= enc_level;
            dm        <= ~enc_level;
            tx_en     <= 1'b1;
            ones      <= in_bit ? ones + CW'(1) : '0;
            last_pend <= in_last;
            if (stuff_hit) begin
              state    <= STUFF;
              in_ready <= 1'b0;
            end else if (in_last) begin
              state    <= EOP_SE0;
              se0_cnt  <= '0;
              in_ready <= 1'b0;
            end else begin
              state    <= DATA;
              in_ready <= 1'b1;
            end
          end else if (state == DATA) begin
            // Underrun: the error pulse and the first SE0 share this cycle.
            err      <= 1'b1;
            dp       <= 1'b0;
            dm       <= 1'b0;
            ones     <= '0;
            in_ready <= 1'b0;
            if (EOP_SE0_CYCLES > 1) begin
              state   <= EOP_SE0;
              se0_cnt <= SW'(1);
            end else begin
              state <= EOP_J;
            end
          end else begin
            dp    <= 1'b1;
            dm    <= 1'b0;
            tx_en <= 1'b0;
          end
        end
        STUFF: begin
          level <= ~level;
          dp    <= ~level;
          dm    <= level;
          ones  <= '0;
          if (last_pend) begin
            state    <= EOP_SE0;
            se0_cnt  <= '0;
            in_ready <= 1'b0;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        EOP_SE0: begin
          dp <= 1'b0;
          dm <= 1'b0;
          if (se0_cnt == SW'(EOP_SE0_CYCLES - 1)) begin
            state <= EOP_J;
          end else begin
            se0_cnt <= se0_cnt + SW'(1);
          end
        end
        EOP_J: begin
          dp       <= 1'b1;
          dm       <= 1'b0;
          tx_en    <= 1'b1;
          level    <= 1'b1;
          ones     <= '0;
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          level    <= 1'b1;
          ones     <= '0;
          dp       <= 1'b1;
          dm       <= 1'b0;
          tx_en    <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_nrzi_tx.sv
`default_nettype none
// tb_usb_nrzi_tx -- scoreboard bench for usb_nrzi_tx; expected line symbols come from a packet-level model.
module tb_usb_nrzi_tx;

  localparam int STUFF_LEN      = 6;
  localparam int EOP_SE0_CYCLES = 2;
  localparam int K_NORMAL       = 0;
  localparam int K_UNDERRUN     = 1;
  localparam int K_ABORT        = 2;

  logic clk      = 1'b0;
  logic rst_L    = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit   = 1'b0;
  logic in_last  = 1'b0;
  logic in_ready, dp, dm, tx_en, err;

  int vectors     = 0;
  int miscompares = 0;

  logic [2:0] exp_q[$];       // {dp, dm, err} per tx_en cycle
  bit         stuff_after[$]; // a stuff bit follows packet bit i
  bit         pkt[$];
  logic [2:0] mon_e;

  usb_nrzi_tx #(
    .STUFF_LEN      (STUFF_LEN),
    .EOP_SE0_CYCLES (EOP_SE0_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_L    (rst_L),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_last  (in_last),
    .in_ready (in_ready),
    .dp       (dp),
    .dm       (dm),
    .tx_en    (tx_en),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line model: walk the packet, toggle on 0, count runs of 1, splice in stuff zeros, append the EOP.
  function automatic void build_expect(input int kind);
    bit lvl = 1'b1;
    int run = 0;
    exp_q.delete();
    stuff_after.delete();
    foreach (pkt[i]) begin
      if (pkt[i]) run++;
      else begin
        lvl = ~lvl;
        run = 0;
      end
      exp_q.push_back({lvl, ~lvl, 1'b0});
      if (run == STUFF_LEN) begin
        lvl = ~lvl;
        run = 0;
        exp_q.push_back({lvl, ~lvl, 1'b0});
        stuff_after.push_back(1'b1);
      end else begin
        stuff_after.push_back(1'b0);
      end
    end
    if (kind != K_ABORT) begin
      for (int s = 0; s < EOP_SE0_CYCLES; s++)
        exp_q.push_back({2'b00, 1'(kind == K_UNDERRUN && s == 0)});
      exp_q.push_back(3'b100);
    end
  endfunction

  task automatic load_bits(input logic [31:0] v, input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(v[i]);
  endtask

  task automatic load_random(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back($urandom_range(0, 3) != 0);
  endtask

  task automatic send_packet(input int kind);
    int waits;
    build_expect(kind);
    for (int i = 0; i < pkt.size(); i++) begin
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 8) begin
        in_valid = 1'b1;
        in_bit   = 1'($urandom);
        in_last  = 1'($urandom);
        waits++;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_bit   = pkt[i];
      in_last  = (kind == K_NORMAL) && (i == pkt.size() - 1);
      if (i > 0) check("ready_wait", waits, {31'd0, stuff_after[i-1]});
      @(posedge clk);
    end
    if (kind != K_ABORT) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_bit   = 1'b0;
      in_last  = 1'b0;
      waits    = 0;
      while (tx_en && waits < 40) begin
        @(negedge clk);
        waits++;
      end
      #1;
      check("eop_timeout", {31'd0, tx_en}, 32'd0);
      check("drain", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic reset_pulse();
    #2;
    rst_L    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check("async_rst", {tx_en, dp, dm, err, in_ready}, 32'b01001);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_L = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_L) begin
      if (tx_en) begin
        if (exp_q.size() == 0) begin
          check("tx_en_extra", {tx_en, dp, dm, err}, 32'b0100);
        end else begin
          mon_e = exp_q.pop_front();
          check("line", {dp, dm, err}, {29'd0, mon_e});
        end
      end else begin
        check("idle", {tx_en, dp, dm, err}, 32'b0100);
      end
    end
  end

  initial begin
    #1 rst_L = 1'b0;
    #1;
    check("reset_async", {tx_en, dp, dm, err, in_ready}, 32'b01001);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {tx_en, dp, dm, err, in_ready}, 32'b01001);
    @(negedge clk);
    rst_L = 1'b1;
    repeat (2) @(negedge clk);

    load_bits(32'h80, 8);          // SYNC
    send_packet(K_NORMAL);
    load_bits(32'h1FE, 9);         // 0 then eight 1s
    send_packet(K_NORMAL);
    load_bits(32'h7E, 7);          // stuff triggered by the last bit
    send_packet(K_NORMAL);
    load_bits(32'h5, 3);           // underrun after 3 bits
    send_packet(K_UNDERRUN);
    load_bits(32'h3E, 6);          // abort with five 1s outstanding
    send_packet(K_ABORT);
    reset_pulse();
    load_bits(32'hFF, 8);          // fresh packet must stuff after its own 6th 1
    send_packet(K_NORMAL);

    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      load_random($urandom_range(1, 24));
      case ($urandom_range(0, 7))
        0, 1:    send_packet(K_UNDERRUN);
        2: begin
          send_packet(K_ABORT);
          reset_pulse();
        end
        default: send_packet(K_NORMAL);
      endcase
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
